// File: rtl/decode_issue_unit_pkg.sv
// Shared decode definitions: widths, RV32I opcodes, immediate formats and queue entry layout.
package decode_issue_unit_pkg;

  localparam int unsigned INST_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_TAG_W = 4;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned OPCODE_W  = 7;

  localparam logic [OPCODE_W-1:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPCODE_B     = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPCODE_L     = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_S     = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPCODE_CALI  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPCODE_CAL   = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              pre_j;
  } iq_entry_t;

  function automatic imm_fmt_e imm_fmt(input logic [OPCODE_W-1:0] opcode);
    case (opcode)
      OPCODE_L, OPCODE_CALI, OPCODE_JALR: return IMM_I;
      OPCODE_S:                           return IMM_S;
      OPCODE_B:                           return IMM_B;
      OPCODE_LUI, OPCODE_AUIPC:           return IMM_U;
      OPCODE_JAL:                         return IMM_J;
      default:                            return IMM_NONE;
    endcase
  endfunction

  // Takes inst[31:7]; the opcode bits never contribute to an immediate.
  function automatic logic [DATA_W-1:0] gen_imm(input logic [31:7] ib, input imm_fmt_e fmt);
    logic [DATA_W-1:0] imm;
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{ib[31]}}, ib[31:20]};
      IMM_S: imm = {{20{ib[31]}}, ib[31:25], ib[11:7]};
      IMM_B: imm = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
      IMM_U: imm = {ib[31:12], 12'b0};
      IMM_J: imm = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_issue_unit_if.sv
// Fetch, operand query, broadcast, back-pressure and issue signals of the decode/issue stage.
interface decode_issue_unit_if #(
  parameter int unsigned ROB_W = decode_issue_unit_pkg::ROB_TAG_W,
  parameter int unsigned N_CDB = 2,
  parameter int unsigned XLEN  = decode_issue_unit_pkg::DATA_W
);
  logic                    if_valid;
  logic                    if_ready;
  logic [31:0]             if_inst;
  logic [XLEN-1:0]         if_pc;
  logic                    if_pre_j;

  logic [4:0]              reg_rs1;
  logic [4:0]              reg_rs2;
  logic                    reg_rs1_rdy;
  logic                    reg_rs2_rdy;
  logic [XLEN-1:0]         reg_rs1_val;
  logic [XLEN-1:0]         reg_rs2_val;
  logic [ROB_W-1:0]        reg_rs1_tag;
  logic [ROB_W-1:0]        reg_rs2_tag;

  logic [ROB_W-1:0]        rob_q1_tag;
  logic [ROB_W-1:0]        rob_q2_tag;
  logic                    rob_q1_rdy;
  logic                    rob_q2_rdy;
  logic [XLEN-1:0]         rob_q1_val;
  logic [XLEN-1:0]         rob_q2_val;

  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*ROB_W-1:0]  cdb_tag;
  logic [N_CDB*XLEN-1:0]   cdb_val;

  logic                    rob_full;
  logic                    rs_full;
  logic                    lsb_full;
  logic [ROB_W-1:0]        rob_alloc_tag;

  logic                    issue;
  logic                    rs_en;
  logic                    lsb_en;
  logic [ROB_W-1:0]        iss_rob_tag;
  logic [6:0]              iss_opcode;
  logic [2:0]              iss_funct3;
  logic                    iss_funct7;
  logic                    iss_rs1_rdy;
  logic                    iss_rs2_rdy;
  logic [XLEN-1:0]         iss_rs1_val;
  logic [XLEN-1:0]         iss_rs2_val;
  logic [ROB_W-1:0]        iss_rs1_tag;
  logic [ROB_W-1:0]        iss_rs2_tag;
  logic [XLEN-1:0]         iss_imm;
  logic [4:0]              iss_rd;
  logic [XLEN-1:0]         iss_pc;
  logic                    iss_pre_j;

  modport slave (
    input  if_valid, if_inst, if_pc, if_pre_j,
    input  reg_rs1_rdy, reg_rs2_rdy, reg_rs1_val, reg_rs2_val, reg_rs1_tag, reg_rs2_tag,
    input  rob_q1_rdy, rob_q2_rdy, rob_q1_val, rob_q2_val,
    input  cdb_valid, cdb_tag, cdb_val,
    input  rob_full, rs_full, lsb_full, rob_alloc_tag,
    output if_ready, reg_rs1, reg_rs2, rob_q1_tag, rob_q2_tag,
    output issue, rs_en, lsb_en, iss_rob_tag, iss_opcode, iss_funct3, iss_funct7,
    output iss_rs1_rdy, iss_rs2_rdy, iss_rs1_val, iss_rs2_val, iss_rs1_tag, iss_rs2_tag,
    output iss_imm, iss_rd, iss_pc, iss_pre_j
  );

  modport master (
    output if_valid, if_inst, if_pc, if_pre_j,
    output reg_rs1_rdy, reg_rs2_rdy, reg_rs1_val, reg_rs2_val, reg_rs1_tag, reg_rs2_tag,
    output rob_q1_rdy, rob_q2_rdy, rob_q1_val, rob_q2_val,
    output cdb_valid, cdb_tag, cdb_val,
    output rob_full, rs_full, lsb_full, rob_alloc_tag,
    input  if_ready, reg_rs1, reg_rs2, rob_q1_tag, rob_q2_tag,
    input  issue, rs_en, lsb_en, iss_rob_tag, iss_opcode, iss_funct3, iss_funct7,
    input  iss_rs1_rdy, iss_rs2_rdy, iss_rs1_val, iss_rs2_val, iss_rs1_tag, iss_rs2_tag,
    input  iss_imm, iss_rd, iss_pc, iss_pre_j
  );
endinterface

// File: rtl/decode_issue_unit_operand_resolver.sv
// Combinational operand lookup: RegFile, then lowest matching broadcast channel, then RoB.
module decode_issue_unit_operand_resolver #(
  parameter int unsigned N_CDB = 2,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                   used,
  input  logic                   reg_rdy,
  input  logic [XLEN-1:0]        reg_val,
  input  logic [ROB_W-1:0]       reg_tag,
  input  logic [N_CDB-1:0]       cdb_valid,
  input  logic [N_CDB*ROB_W-1:0] cdb_tag,
  input  logic [N_CDB*XLEN-1:0]  cdb_val,
  input  logic                   rob_rdy,
  input  logic [XLEN-1:0]        rob_val,
  output logic                   rdy_c,
  output logic [XLEN-1:0]        val_c,
  output logic [ROB_W-1:0]       tag_c
);

  logic cdb_hit;

  always_comb begin
    rdy_c   = 1'b0;
    val_c   = '0;
    tag_c   = reg_tag;
    cdb_hit = 1'b0;
    if (!used) begin
      rdy_c = 1'b1;
      tag_c = '0;
    end else if (reg_rdy) begin
      rdy_c = 1'b1;
      val_c = reg_val;
      tag_c = '0;
    end else begin
      // Ascending scan with a sticky hit gives channel 0 the highest priority.
      for (int i = 0; i < int'(N_CDB); i++) begin
        if (!cdb_hit && cdb_valid[i] && (cdb_tag[i*int'(ROB_W) +: ROB_W] == reg_tag)) begin
          cdb_hit = 1'b1;
          val_c   = cdb_val[i*int'(XLEN) +: XLEN];
        end
      end
      if (cdb_hit) begin
        rdy_c = 1'b1;
        tag_c = '0;
      end else if (rob_rdy) begin
        rdy_c = 1'b1;
        val_c = rob_val;
        tag_c = '0;
      end
    end
  end

endmodule

// File: rtl/decode_issue_unit.sv
// Decode/issue stage: instruction queue, head decode, operand resolution and registered issue.
module decode_issue_unit
  import decode_issue_unit_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = 8,
  parameter int unsigned ROB_W    = ROB_TAG_W,
  parameter int unsigned N_CDB    = 2,
  parameter int unsigned XLEN     = DATA_W
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 rdy,
  input logic                 rollback,
  decode_issue_unit_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  iq_entry_t          mem [IQ_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;

  iq_entry_t          head_e;
  logic [6:0]         opcode;
  logic               needs_rs;
  logic               needs_lsb;
  logic               rs1_used;
  logic               rs2_used;
  logic               rd_zero;
  logic [DATA_W-1:0]  imm_c;
  logic               enq_c;
  logic               fire_c;

  logic               rs1_rdy_c;
  logic               rs2_rdy_c;
  logic [XLEN-1:0]    rs1_val_c;
  logic [XLEN-1:0]    rs2_val_c;
  logic [ROB_W-1:0]   rs1_tag_c;
  logic [ROB_W-1:0]   rs2_tag_c;

  assign head_e = mem[head];
  assign opcode = head_e.inst[6:0];
  assign imm_c  = gen_imm(head_e.inst[31:7], imm_fmt(opcode));

  // Head decode: destination unit and which source operands are real.
  always_comb begin
    needs_rs  = 1'b0;
    needs_lsb = 1'b0;
    rs1_used  = 1'b1;
    rs2_used  = 1'b1;
    rd_zero   = 1'b0;
    case (opcode)
      OPCODE_L: begin
        needs_lsb = 1'b1;
        rs2_used  = 1'b0;
      end
      OPCODE_S: begin
        needs_lsb = 1'b1;
        rd_zero   = 1'b1;
      end
      OPCODE_CAL: needs_rs = 1'b1;
      OPCODE_CALI, OPCODE_JALR: begin
        needs_rs = 1'b1;
        rs2_used = 1'b0;
      end
      OPCODE_B: begin
        needs_rs = 1'b1;
        rd_zero  = 1'b1;
      end
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: begin
        needs_rs = 1'b1;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
      end
      default: ;
    endcase
  end

  // Query indices are masked while empty so stale queue contents never leak out.
  assign bus.reg_rs1    = (count != '0) ? head_e.inst[19:15] : '0;
  assign bus.reg_rs2    = (count != '0) ? head_e.inst[24:20] : '0;
  assign bus.rob_q1_tag = bus.reg_rs1_tag;
  assign bus.rob_q2_tag = bus.reg_rs2_tag;

  assign enq_c  = bus.if_valid && bus.if_ready;
  assign fire_c = (count != '0) && !bus.rob_full
               && !(needs_rs && bus.rs_full) && !(needs_lsb && bus.lsb_full);

  decode_issue_unit_operand_resolver #(.N_CDB(N_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_rs1 (
    .used      (rs1_used),
    .reg_rdy   (bus.reg_rs1_rdy),
    .reg_val   (bus.reg_rs1_val),
    .reg_tag   (bus.reg_rs1_tag),
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_tag),
    .cdb_val   (bus.cdb_val),
    .rob_rdy   (bus.rob_q1_rdy),
    .rob_val   (bus.rob_q1_val),
    .rdy_c     (rs1_rdy_c),
    .val_c     (rs1_val_c),
    .tag_c     (rs1_tag_c)
  );

  decode_issue_unit_operand_resolver #(.N_CDB(N_CDB), .ROB_W(ROB_W), .XLEN(XLEN)) u_rs2 (
    .used      (rs2_used),
    .reg_rdy   (bus.reg_rs2_rdy),
    .reg_val   (bus.reg_rs2_val),
    .reg_tag   (bus.reg_rs2_tag),
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (bus.cdb_tag),
    .cdb_val   (bus.cdb_val),
    .rob_rdy   (bus.rob_q2_rdy),
    .rob_val   (bus.rob_q2_val),
    .rdy_c     (rs2_rdy_c),
    .val_c     (rs2_val_c),
    .tag_c     (rs2_tag_c)
  );

  always_comb begin
    count_nxt = count;
    if (enq_c && !fire_c) begin
      count_nxt = count + CNT_W'(1);
    end else if (!enq_c && fire_c) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Queue storage carries no reset; entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (rdy && !rollback && enq_c) begin
      mem[tail] <= '{inst: bus.if_inst, pc: ADDR_W'(bus.if_pc), pre_j: bus.if_pre_j};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      bus.if_ready    <= 1'b1;
      bus.issue       <= 1'b0;
      bus.rs_en       <= 1'b0;
      bus.lsb_en      <= 1'b0;
      bus.iss_rob_tag <= '0;
      bus.iss_opcode  <= '0;
      bus.iss_funct3  <= '0;
      bus.iss_funct7  <= 1'b0;
      bus.iss_rs1_rdy <= 1'b0;
      bus.iss_rs2_rdy <= 1'b0;
      bus.iss_rs1_val <= '0;
      bus.iss_rs2_val <= '0;
      bus.iss_rs1_tag <= '0;
      bus.iss_rs2_tag <= '0;
      bus.iss_imm     <= '0;
      bus.iss_rd      <= '0;
      bus.iss_pc      <= '0;
      bus.iss_pre_j   <= 1'b0;
    end else if (rdy) begin
      if (rollback) begin
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        bus.if_ready <= 1'b1;
        bus.issue    <= 1'b0;
      end else begin
        if (enq_c) tail <= tail + PTR_W'(1);
        if (fire_c) head <= head + PTR_W'(1);
        count        <= count_nxt;
        bus.if_ready <= (count_nxt < CNT_W'(IQ_DEPTH));
        bus.issue    <= fire_c;
        // Payload registers only move on a fire so they stay stable between issues.
        if (fire_c) begin
          bus.rs_en       <= needs_rs;
          bus.lsb_en      <= needs_lsb;
          bus.iss_rob_tag <= bus.rob_alloc_tag;
          bus.iss_opcode  <= opcode;
          bus.iss_funct3  <= head_e.inst[14:12];
          bus.iss_funct7  <= head_e.inst[30];
          bus.iss_rs1_rdy <= rs1_rdy_c;
          bus.iss_rs2_rdy <= rs2_rdy_c;
          bus.iss_rs1_val <= rs1_val_c;
          bus.iss_rs2_val <= rs2_val_c;
          bus.iss_rs1_tag <= rs1_tag_c;
          bus.iss_rs2_tag <= rs2_tag_c;
          bus.iss_imm     <= XLEN'(imm_c);
          bus.iss_rd      <= rd_zero ? 5'd0 : head_e.inst[11:7];
          bus.iss_pc      <= XLEN'(head_e.pc);
          bus.iss_pre_j   <= head_e.pre_j;
        end
      end
    end
  end

endmodule

// File: doc/decode_issue_unit.md
Name: decode_issue_unit

Overview:
Registered decode/issue stage for the out-of-order RISC-V core. It sits between IFetch and the RS/LSB/RoB.
- Buffers fetched instructions in a parametrised instruction queue.
- Decodes the head instruction and resolves its operands from the RegFile, N_CDB result broadcast channels, and the RoB.
- Issues at most one instruction per cycle, stalling on back-pressure.
- Flushes on rollback.

Parameters:
IQ_DEPTH, 8, instruction queue entries; power of 2, ≥2
ROB_W, 4, RoB index width
N_CDB, 2, number of result broadcast channels (ALU, LSB, ...)
XLEN, 32, data/address width

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; low freezes all state
rollback  in  1  mispredict flush
if_valid  in  1  fetch presents instruction
if_ready  out  1  queue can accept
if_inst  in  32  instruction word
if_pc  in  XLEN  instruction pc
if_pre_j  in  1  predicted-taken flag
reg_rs1, reg_rs2  out  5  RegFile query indices (head inst)
reg_rs1_rdy, reg_rs2_rdy  in  1  operand committed
reg_rs1_val, reg_rs2_val  in  XLEN  committed value
reg_rs1_tag, reg_rs2_tag  in  ROB_W  producing RoB entry
rob_q1_tag, rob_q2_tag  out  ROB_W  RoB query (= reg tags)
rob_q1_rdy, rob_q2_rdy  in  1  RoB entry has result
rob_q1_val, rob_q2_val  in  XLEN  RoB result
cdb_valid  in  N_CDB  broadcast valid per channel
cdb_tag  in  N_CDB*ROB_W  packed tags, channel 0 at LSBs
cdb_val  in  N_CDB*XLEN  packed values
rob_full, rs_full, lsb_full  in  1  back-pressure
rob_alloc_tag  in  ROB_W  RoB slot the next issue takes
issue  out  1  one-cycle issue pulse
rs_en, lsb_en  out  1  destination select (both 0 = RoB only)
iss_rob_tag  out  ROB_W  allocated RoB slot
iss_opcode  out  7  opcode
iss_funct3  out  3  funct3
iss_funct7  out  1  inst[30]
iss_rs1_rdy, iss_rs2_rdy  out  1  operand resolved
iss_rs1_val, iss_rs2_val  out  XLEN  operand value (0 if not ready)
iss_rs1_tag, iss_rs2_tag  out  ROB_W  wait tag (0 if ready)
iss_imm  out  XLEN  sign-extended immediate
iss_rd  out  5  destination (0 for S/B)
iss_pc  out  XLEN  pc
iss_pre_j  out  1  prediction flag

Behaviour:
- Reset is rst, synchronous, active-high. It clears head, tail and count. All outputs are 0 at reset, except if_ready = 1.
- rdy low: no state change, registered outputs hold.
- Enqueue when if_valid && if_ready. if_ready = (count < IQ_DEPTH). Dequeue does not raise if_ready in the same cycle.
- Pointers are log2(IQ_DEPTH) bits and wrap naturally. count is log2(IQ_DEPTH)+1 bits.
- Head fires when count>0 && !rob_full && !(needs_rs && rs_full) && !(needs_lsb && lsb_full).
  - needs_lsb: opcode L or S.
  - needs_rs: CAL, CALI, B, LUI, AUIPC, JAL, JALR.
  - Unknown opcode: both 0; issued to RoB only.
- Latency: the head decoded in cycle t drives registered outputs in cycle t+1, with issue=1 for exactly that cycle. Otherwise issue=0 and the other outputs are don't-care but stable.
- Operand resolution, evaluated in the fire cycle, first match wins:
  1. reg_rdy: take the RegFile value.
  2. Lowest-index CDB channel with cdb_valid and a matching tag: take its value, rdy=1.
  3. rob_q_rdy: take the RoB value, rdy=1.
  4. Otherwise rdy=0, val=0, tag=reg tag.
- Unused operands are forced to rdy=1, val=0, tag=0.
  - rs2 unused: L, CALI, JALR, LUI, AUIPC, JAL.
  - rs1 unused: LUI, AUIPC, JAL.
- Broadcasts during the issue-presentation cycle t+1 are the receiver's responsibility.
- Immediates:
  - I (L, CALI, JALR): sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U: {inst[31:12], 12'b0}.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - CAL: 0.
- rd is forced to 0 for S and B.
- rollback (with rdy): queue emptied and issue=0 next cycle. Enqueue and fire in the same cycle are discarded. rollback has priority over every other event.
- Simultaneous enqueue and dequeue when not full: count unchanged.
- Queue full with the head stalled: if_ready=0, the fetch instruction is held upstream.

Decomposition:
- Shared package (def.v): OPCODE_* constants, INST/ADDR/DATA/ROB width macros, and a new immediate-format enum.
- One natural sub-module, operand_resolver: combinational; instantiated twice (rs1, rs2); parametrised by N_CDB; implements the priority chain.
- The queue and output registers stay in the top.

Test Plan:
- Reset, then enqueue `addi x1,x0,5` (0x00500093), all ready → next cycle issue=1, rs_en=1, imm=5, rd=1, rs1_rdy=1, rs2_rdy=1.
- Fill 8 entries with rob_full=1 → if_ready=0 after the 8th; release → one issue per cycle for 8 cycles, pc order preserved, if_ready=1 one cycle after the first dequeue.
- `add x3,x1,x2` with x1 tag 3 pending, cdb_valid=2'b11, both channels tag 3 with values 0xA and 0xB → iss_rs1_val=0xA (channel 0 wins), rs1_rdy=1. x2 tag 5 with rob_q2_rdy=0 → rs2_rdy=0, rs2_tag=5.
- `sw x2,-4(x1)` (0xFE20AE23) with lsb_full=1 for 3 cycles → no issue during the stall; then lsb_en=1, rd=0, imm=0xFFFFFFFC.
- rollback asserted while 4 entries are queued and if_valid=1 → no issue next cycle, count=0, the following fetch issues 2 cycles later.
- rdy=0 for 5 cycles mid-stream → state and outputs frozen, no lost or duplicated instruction.
